// File: rtl/decim_pkg.sv
// decim_pkg: shared widths and the reciprocal table for the block-averaging decimator.
// Optional feature macro DECIM_ROUND_EN (used in decim_scale) selects round-half-up scaling.
package decim_pkg;

    localparam int DW    = 18;            // sample width, signed
    localparam int NW    = 4;             // decimation ratio width, ratios 1..15
    localparam int RW    = 24;            // reciprocal width, unsigned
    localparam int FRAC  = RW - 1;        // reciprocal fraction bits
    localparam int ACC_W = DW + NW;       // accumulator width, cannot overflow for n <= 15
    localparam int PW    = ACC_W + RW + 1; // product width (reciprocal gets a zero sign bit)

    // round(2^23 / n); index 0 and 1 both map to unity gain.
    function automatic logic [RW-1:0] recip(input logic [NW-1:0] n);
        case (n)
            4'd2:    recip = 24'd4194304;
            4'd3:    recip = 24'd2796203;
            4'd4:    recip = 24'd2097152;
            4'd5:    recip = 24'd1677722;
            4'd6:    recip = 24'd1398101;
            4'd7:    recip = 24'd1198373;
            4'd8:    recip = 24'd1048576;
            4'd9:    recip = 24'd932068;
            4'd10:   recip = 24'd838861;
            4'd11:   recip = 24'd762601;
            4'd12:   recip = 24'd699051;
            4'd13:   recip = 24'd645278;
            4'd14:   recip = 24'd599186;
            4'd15:   recip = 24'd559241;
            default: recip = 24'd8388608;
        endcase
    endfunction

endpackage

// File: rtl/decim_scale.sv
// decim_scale: multiplies a block sum by 1/n, optionally rounds, saturates and registers
// the averaged sample. Two register stages: product, then output.
// DECIM_ROUND_EN defined: round half toward +inf; undefined: truncate toward -inf.
module decim_scale
    import decim_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ACC_W-1:0]  sum,
    input  logic [NW-1:0]     n,
    output logic              out_valid,
    output logic [DW-1:0]     out_data
);

    localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (DW - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) <<< (DW - 1));

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;
    logic                 prod_valid;
    logic signed [PW-1:0] prod_adj;
    logic signed [PW-1:0] quo;
    logic [DW-1:0]        sat_d;

    // Signed sum times zero-extended unsigned reciprocal, all at product width.
    always_comb begin
        prod_d = PW'($signed(sum)) * PW'($signed({1'b0, recip(n)}));
    end

    // Drop the fraction bits (optionally rounding first) and clamp to the sample range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sat_d = quo[DW-1:0];
`ifdef DECIM_ROUND_EN
        prod_adj = prod_q + (PW'(1) <<< (FRAC - 1));
`else
        prod_adj = prod_q;
`endif
        quo = prod_adj >>> FRAC;
        if (quo > SAT_MAX) begin
            sat_d = SAT_MAX[DW-1:0];
        end else if (quo < SAT_MIN) begin
            sat_d = SAT_MIN[DW-1:0];
        end else begin
            sat_d = quo[DW-1:0];
        end
    end

    // Product stage then output stage; dataout holds between strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_valid <= 1'b0;
            prod_q     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            // NOTE: non-blocking so each stage samples the previous stage's old value.
            prod_valid <= in_valid;
            if (in_valid) begin
                prod_q <= prod_d;
            end
            out_valid <= prod_valid;
            if (prod_valid) begin
                out_data <= sat_d;
            end
        end
    end

endmodule

// File: rtl/decimator.sv
// decimator: accumulates Nfreq input samples per block and emits their average two
// cycles after the last sample of the block. Ratio 0 is treated as 1.
// Rounding mode is selected in decim_scale by the DECIM_ROUND_EN macro.
module decimator
    import decim_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           endatain,
    input  logic [NW-1:0]  Nfreq,
    input  logic [DW-1:0]  datain,
    output logic           endataout,
    output logic [DW-1:0]  dataout
);

    logic [NW-1:0]            cnt;
    logic [NW-1:0]            n_blk;
    logic [NW-1:0]            eff_n;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  sample_ext;
    logic                     last;
    logic                     blk_done;

    // Ratio is taken from Nfreq only at the start of a block, then held in n_blk.
    always_comb begin
        sample_ext = ACC_W'($signed(datain));
        eff_n      = (cnt == '0) ? ((Nfreq == '0) ? NW'(1) : Nfreq) : n_blk;
        acc_d      = (cnt == '0) ? sample_ext : acc + sample_ext;
        last       = (cnt == eff_n - NW'(1));
    end

    // Block counter, accumulator and ratio latch; blk_done marks a finished sum in acc.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            n_blk    <= NW'(1);
            acc      <= '0;
            blk_done <= 1'b0;
        end else begin
            blk_done <= endatain && last;
            if (endatain) begin
                acc <= acc_d;
                if (cnt == '0) begin
                    n_blk <= eff_n;
                end
                cnt <= last ? '0 : cnt + NW'(1);
            end
        end
    end

    // acc and n_blk stay stable for the cycle after blk_done, which is when the
    // scale stage captures them, even if a new block starts on that same edge.
    decim_scale u_scale (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (blk_done),
        .sum       (acc),
        .n         (n_blk),
        .out_valid (endataout),
        .out_data  (dataout)
    );

endmodule

// File: tb/tb_decimator.sv
// tb_decimator: directed tests for the block-averaging decimator, both rounding builds.
module tb_decimator;

    localparam int DW = 18;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          endatain = 1'b0;
    logic [3:0]    Nfreq = 4'd1;
    logic [DW-1:0] datain = '0;
    logic          endataout;
    logic [DW-1:0] dataout;

    int total = 0;
    int bad   = 0;

    decimator dut (
        .clock     (clock),
        .reset     (reset),
        .endatain  (endatain),
        .Nfreq     (Nfreq),
        .datain    (datain),
        .endataout (endataout),
        .dataout   (dataout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int k);
        endatain = 1'b0;
        repeat (k) tick();
    endtask

    // Present one sample on the next edge; endatain stays high for back-to-back use.
    task automatic send(input int v);
        endatain = 1'b1;
        datain   = DW'(v);
        tick();
    endtask

    // Stop strobing and wait (bounded) for the next output strobe.
    task automatic wait_out(input int budget, output bit found, output int lat,
                            output logic [DW-1:0] val);
        found    = 1'b0;
        lat      = 0;
        val      = '0;
        endatain = 1'b0;
        while (!found && lat < budget) begin
            tick();
            lat++;
            if (endataout === 1'b1) begin
                found = 1'b1;
                val   = dataout;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (endataout !== 1'b0) begin
            bad++; $display("FAIL reset_strobe: got %b want 0", endataout);
        end
        total++;
        if (dataout !== '0) begin
            bad++; $display("FAIL reset_data: got %0d want 0", $signed(dataout));
        end
        endatain = 1'b1;
        datain   = DW'(77);
        repeat (3) tick();
        total++;
        if (endataout !== 1'b0 || dataout !== '0) begin
            bad++; $display("FAIL reset_hold: got strobe=%b data=%0d want 0/0", endataout, $signed(dataout));
        end
        endatain = 1'b0;
        #2 reset = 1'b1;
        idle(3);
    endtask

    task automatic test_avg4();
        bit found; int lat; logic [DW-1:0] val;
        Nfreq = 4'd4;
        for (int i = 0; i < 4; i++) begin
            send(100 * (i + 1));
            if (i < 3) begin
                endatain = 1'b0;
                repeat (2) begin
                    tick();
                    total++;
                    if (endataout !== 1'b0) begin
                        bad++; $display("FAIL avg4_early: strobe before 4th sample, sample %0d", i);
                    end
                end
            end
        end
        wait_out(6, found, lat, val);
        total++;
        if (!found || lat != 2) begin
            bad++; $display("FAIL avg4_latency: got found=%0d lat=%0d want 1/2", found, lat);
        end
        total++;
        if (val !== DW'(250)) begin
            bad++; $display("FAIL avg4_value: got %0d want 250", $signed(val));
        end
        tick();
        total++;
        if (endataout !== 1'b0 || dataout !== DW'(250)) begin
            bad++; $display("FAIL avg4_hold: got strobe=%b data=%0d want 0/250", endataout, $signed(dataout));
        end
        idle(2);
    endtask

    task automatic test_round();
        bit found; int lat; logic [DW-1:0] val; int exp_v;
`ifdef DECIM_ROUND_EN
        exp_v = -3;
`else
        exp_v = -4;
`endif
        Nfreq = 4'd2;
        send(-3);
        send(-4);
        wait_out(6, found, lat, val);
        total++;
        if (!found || lat != 2 || val !== DW'(exp_v)) begin
            bad++; $display("FAIL round_half: got found=%0d lat=%0d data=%0d want 1/2/%0d", found, lat, $signed(val), exp_v);
        end
        idle(2);
    endtask

    task automatic test_full_scale();
        bit found; int lat; logic [DW-1:0] val; int exp_v;
        int nf[3]  = '{6, 6, 3};
        int smp[3] = '{131071, -131072, -131072};
        for (int t = 0; t < 3; t++) begin
            exp_v = smp[t];
`ifndef DECIM_ROUND_EN
            if (t == 0) exp_v = 131070;
`endif
            Nfreq = 4'(nf[t]);
            repeat (nf[t]) send(smp[t]);
            wait_out(6, found, lat, val);
            total++;
            if (!found || lat != 2 || val !== DW'(exp_v)) begin
                bad++; $display("FAIL full_scale_%0d: got found=%0d lat=%0d data=%0d want 1/2/%0d", t, found, lat, $signed(val), exp_v);
            end
            idle(2);
        end
    endtask

    task automatic test_ratio_one(input logic [3:0] nf);
        Nfreq = nf;
        idle(4);
        for (int c = 0; c < 12; c++) begin
            endatain = (c < 10);
            datain   = DW'(c);
            tick();
            total++;
            if (endataout !== (c >= 2)) begin
                bad++; $display("FAIL ratio%0d_strobe_%0d: got %b want %0d", nf, c, endataout, (c >= 2));
            end
            if (c >= 2) begin
                total++;
                if (dataout !== DW'(c - 2)) begin
                    bad++; $display("FAIL ratio%0d_data_%0d: got %0d want %0d", nf, c, $signed(dataout), c - 2);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_ratio_change();
        int smp[6] = '{10, 20, 30, 40, 50, 70};
        int got[4];
        int n_out = 0;
        Nfreq = 4'd4;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) Nfreq = 4'd2;
            endatain = (c < 6);
            datain   = DW'((c < 6) ? smp[c] : 0);
            tick();
            if (endataout === 1'b1) begin
                if (n_out < 4) got[n_out] = $signed(dataout);
                n_out++;
            end
        end
        total++;
        if (n_out != 2) begin
            bad++; $display("FAIL ratio_change_count: got %0d strobes want 2", n_out);
        end else begin
            total++;
            if (got[0] != 25) begin
                bad++; $display("FAIL ratio_change_blk0: got %0d want 25", got[0]);
            end
            total++;
            if (got[1] != 60) begin
                bad++; $display("FAIL ratio_change_blk1: got %0d want 60", got[1]);
            end
        end
        idle(2);
    endtask

    task automatic test_async_reset();
        bit found; int lat; logic [DW-1:0] val;
        Nfreq = 4'd4;
        send(1000);
        send(1000);
        endatain = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if (endataout !== 1'b0 || dataout !== '0) begin
            bad++; $display("FAIL async_reset_out: got strobe=%b data=%0d want 0/0", endataout, $signed(dataout));
        end
        #2 reset = 1'b1;
        repeat (4) send(8);
        wait_out(6, found, lat, val);
        total++;
        if (!found || lat != 2 || val !== DW'(8)) begin
            bad++; $display("FAIL async_reset_next: got found=%0d lat=%0d data=%0d want 1/2/8", found, lat, $signed(val));
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_avg4();
        test_round();
        test_full_scale();
        test_ratio_one(4'd1);
        test_ratio_one(4'd0);
        test_ratio_change();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
